// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths, FSM encoding and bubble control for the EX/MEM boundary
package pipe_pkg;

    localparam int DATA_W = 16;
    localparam int REG_W  = 3;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_STALL  = 2'b01,
        ST_HALTED = 2'b10
    } state_e;

    typedef struct packed {
        logic valid;
        logic reg_en;
        logic mem_en;
        logic mem_wr;
        logic halt;
    } ctrl_t;

    localparam ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/ex_mem_reg_if.sv
// rtl/ex_mem_reg_if.sv - EX-side inputs, MEM-side outputs and pipe control of the EX/MEM register
interface ex_mem_reg_if #(
    parameter int DATA_W = pipe_pkg::DATA_W,
    parameter int REG_W  = pipe_pkg::REG_W
);
    logic              valid_EX;
    logic [REG_W-1:0]  w1_reg_EX;
    logic              reg_en_EX;
    logic              mem_en_EX;
    logic              mem_wr_EX;
    logic [DATA_W-1:0] alu_out_EX;
    logic [DATA_W-1:0] r2_EX;
    logic [DATA_W-1:0] pc_add2_EX;
    logic [DATA_W-1:0] instr_EX;
    logic              halt_EX;
    logic              stall_mem;
    logic              flush;

    logic              valid_EX_MEM;
    logic [REG_W-1:0]  w1_reg_EX_MEM;
    logic              reg_en_EX_MEM;
    logic              mem_en_EX_MEM;
    logic              mem_wr_EX_MEM;
    logic [DATA_W-1:0] alu_out_EX_MEM;
    logic [DATA_W-1:0] r2_EX_MEM;
    logic [DATA_W-1:0] pc_add2_EX_MEM;
    logic [DATA_W-1:0] instr_EX_MEM;
    logic              halt_EX_MEM;
    logic              stall_up;
    logic              halted;
    logic [15:0]       stall_cnt;

    modport master (
        output valid_EX, w1_reg_EX, reg_en_EX, mem_en_EX, mem_wr_EX,
               alu_out_EX, r2_EX, pc_add2_EX, instr_EX, halt_EX, stall_mem, flush,
        input  valid_EX_MEM, w1_reg_EX_MEM, reg_en_EX_MEM, mem_en_EX_MEM, mem_wr_EX_MEM,
               alu_out_EX_MEM, r2_EX_MEM, pc_add2_EX_MEM, instr_EX_MEM, halt_EX_MEM,
               stall_up, halted, stall_cnt
    );

    modport slave (
        input  valid_EX, w1_reg_EX, reg_en_EX, mem_en_EX, mem_wr_EX,
               alu_out_EX, r2_EX, pc_add2_EX, instr_EX, halt_EX, stall_mem, flush,
        output valid_EX_MEM, w1_reg_EX_MEM, reg_en_EX_MEM, mem_en_EX_MEM, mem_wr_EX_MEM,
               alu_out_EX_MEM, r2_EX_MEM, pc_add2_EX_MEM, instr_EX_MEM, halt_EX_MEM,
               stall_up, halted, stall_cnt
    );

endinterface

// File: rtl/dffe_n.sv
// rtl/dffe_n.sv - single-bit enable flop with asynchronous active-low reset
module dffe_n (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic d_i,
    output logic q_o
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_o <= 1'b0;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/ex_mem_reg.sv
// rtl/ex_mem_reg.sv - EX/MEM pipeline register with stall hold, deferred flush and halt; EX_MEM_STALL_CNT_EN adds a stall counter
module ex_mem_reg #(
    parameter int DATA_W = pipe_pkg::DATA_W,
    parameter int REG_W  = pipe_pkg::REG_W
) (
    input  logic         clk,
    input  logic         rst,
    ex_mem_reg_if.slave  bus
);
    import pipe_pkg::*;

    localparam int CTRL_W  = $bits(ctrl_t);
    localparam int ENTRY_W = CTRL_W + REG_W + 4 * DATA_W;

    state_e             state_q, state_d;
    logic               flush_pend_q, flush_pend_d;
    logic               load;
    logic               bubble;

    ctrl_t              ctrl_in, ctrl_q;
    logic [ENTRY_W-1:0] entry_in, entry_d, entry_q;
    logic [REG_W-1:0]   w1_q;
    logic [DATA_W-1:0]  alu_q, r2_q, pc_q, instr_q;
    logic               is_halted;

    assign ctrl_in  = {bus.valid_EX, bus.reg_en_EX, bus.mem_en_EX, bus.mem_wr_EX, bus.halt_EX};
    assign entry_in = {ctrl_in, bus.w1_reg_EX, bus.alu_out_EX, bus.r2_EX, bus.pc_add2_EX, bus.instr_EX};

    // A pending flush from a stall is consumed by the first edge that loads again.
    assign bubble  = bus.flush | flush_pend_q | ~bus.valid_EX;
    assign entry_d = bubble ? {BUBBLE_CTRL, {(ENTRY_W - CTRL_W){1'b0}}} : entry_in;

    for (genvar i = 0; i < ENTRY_W; i++) begin : g_bit
        dffe_n u_ff (
            .clk   (clk),
            .rst_n (rst),
            .en_i  (load),
            .d_i   (entry_d[i]),
            .q_o   (entry_q[i])
        );
    end

    assign {ctrl_q, w1_q, alu_q, r2_q, pc_q, instr_q} = entry_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_RUN;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    // A captured valid HALT takes priority over a stall arriving on the same cycle.
    always_comb begin
        state_d      = state_q;
        flush_pend_d = flush_pend_q;
        load         = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (ctrl_q.valid && ctrl_q.halt) begin
                    state_d = ST_HALTED;
                end else if (bus.stall_mem && ctrl_q.valid) begin
                    state_d = ST_STALL;
                end else begin
                    load = 1'b1;
                end
            end
            ST_STALL: begin
                if (ctrl_q.valid && ctrl_q.halt) begin
                    state_d = ST_HALTED;
                end else if (!bus.stall_mem) begin
                    state_d = ST_RUN;
                    load    = 1'b1;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        if (load) begin
            flush_pend_d = 1'b0;
        end else if (state_q != ST_HALTED) begin
            flush_pend_d = flush_pend_q | bus.flush;
        end
    end

    assign is_halted = (state_q == ST_HALTED);

    assign bus.valid_EX_MEM   = ctrl_q.valid;
    assign bus.w1_reg_EX_MEM  = w1_q;
    assign bus.reg_en_EX_MEM  = ctrl_q.reg_en & ctrl_q.valid;
    assign bus.mem_en_EX_MEM  = ctrl_q.mem_en & ctrl_q.valid & ~is_halted;
    assign bus.mem_wr_EX_MEM  = ctrl_q.mem_wr & ctrl_q.valid & ~is_halted;
    assign bus.halt_EX_MEM    = ctrl_q.halt & ctrl_q.valid;
    assign bus.alu_out_EX_MEM = alu_q;
    assign bus.r2_EX_MEM      = r2_q;
    assign bus.pc_add2_EX_MEM = pc_q;
    assign bus.instr_EX_MEM   = instr_q;
    assign bus.stall_up       = (state_q == ST_STALL) | is_halted;
    assign bus.halted         = is_halted;

`ifdef EX_MEM_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == ST_STALL && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= 16'h0000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
`else
    assign bus.stall_cnt = 16'h0000;
`endif

endmodule
